pipe_issue: RTL and testbench

PIPE_ISSUE -- requirements
Module: pipe_issue

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_issue_fifo.sv | 59 +++++
 rtl/pipe_issue.sv | 165 ++++++++++++++++
 tb/tb_pipe_issue.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the issue stage: instruction layout, opcodes, FSM states.
package pipe_pkg;

  localparam int INSTR_W  = 24;
  localparam int FUNC_W   = 4;
  localparam int REG_W    = 4;
  localparam int ADDR_W   = 8;

  localparam int FUNC_LSB = 20;
  localparam int RS1_LSB  = 16;
  localparam int RS2_LSB  = 12;
  localparam int RD_LSB   = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD = 4'd0,
    FUNC_SUB = 4'd1,
    FUNC_MUL = 4'd2,
    FUNC_DIV = 4'd3,
    FUNC_AND = 4'd4,
    FUNC_OR  = 4'd5,
    FUNC_XOR = 4'd6,
    FUNC_NOT = 4'd7,
    FUNC_SLL = 4'd8,
    FUNC_SRL = 4'd9,
    FUNC_SRA = 4'd10,
    FUNC_SLA = 4'd11
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } issue_state_t;

endpackage

// File: rtl/pipe_issue_fifo.sv
// Synchronous instruction queue with push/pop/flush; flush wins over push and pop.
// Latency: pushed word visible at pop_dat the cycle after the push.
// Backpressure: full stays high while DEPTH entries are held, even if a pop is underway.
module pipe_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// In-order issue stage with RAW scoreboard; PIPE_ISSUE_STATS_EN enables the stall counter.
// Latency: 1 cycle from push into an empty queue to issue_valid.
// Backpressure: in_ready = queue not full; hazardous head emits bubbles until the window drains.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HAZ_WIN    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_instr,
  output logic        issue_valid,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic [15:0] stall_cnt
);

  logic [INSTR_W-1:0] head;
  logic               q_full;
  logic               q_empty;
  logic               pop_en;
  logic               hazard;
  issue_state_t       state_q;
  issue_state_t       state_d;

  logic [FUNC_W-1:0]  head_func;
  logic [REG_W-1:0]   head_rs1;
  logic [REG_W-1:0]   head_rs2;
  logic [REG_W-1:0]   head_rd;
  logic [ADDR_W-1:0]  head_addr;

  logic               sb_vld [HAZ_WIN];
  logic [REG_W-1:0]   sb_rd  [HAZ_WIN];

  assign in_ready = ~q_full;

  pipe_issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (in_valid & ~q_full),
    .push_dat (in_instr),
    .pop      (pop_en),
    .pop_dat  (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign head_func = head[FUNC_LSB +: FUNC_W];
  assign head_rs1  = head[RS1_LSB  +: REG_W];
  assign head_rs2  = head[RS2_LSB  +: REG_W];
  assign head_rd   = head[RD_LSB   +: REG_W];
  assign head_addr = head[ADDR_LSB +: ADDR_W];

  // Both sources are checked regardless of opcode.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_vld[i] && (sb_rd[i] == head_rs1 || sb_rd[i] == head_rs2)) hazard = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ISSUE, ST_STALL: begin
        if (q_empty) begin
          state_d = ST_IDLE;
        end else if (hazard) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_ISSUE;
          pop_en  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      pop_en  = 1'b0;
    end
  end

  // A bubble shifts an invalid entry in, so a blocked head waits at most HAZ_WIN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HAZ_WIN; i++) begin
        sb_vld[i] <= 1'b0;
        sb_rd[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < HAZ_WIN; i++) begin
        sb_vld[i] <= 1'b0;
        sb_rd[i]  <= '0;
      end
    end else begin
      sb_vld[0] <= pop_en;
      sb_rd[0]  <= pop_en ? head_rd : '0;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      func        <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      addr        <= '0;
    end else if (pop_en) begin
      issue_valid <= 1'b1;
      func        <= head_func;
      rs1         <= head_rs1;
      rs2         <= head_rs2;
      rd          <= head_rd;
      addr        <= head_addr;
    end else begin
      issue_valid <= 1'b0;
      func        <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      addr        <= '0;
    end
  end

`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (state_d == ST_STALL && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_issue.sv
// Randomized and directed bench for pipe_issue against a cycle-count based reference model.
module tb_pipe_issue;

  localparam int DEPTH = 4;
  localparam int HZ    = 2;
`ifdef PIPE_ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [41:0] RST_OBS = {1'b0, 24'h0, 1'b1, 16'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_instr = '0;
  logic        in_ready;
  logic        issue_valid;
  logic [3:0]  o_rs1, o_rs2, o_rd, o_func;
  logic [7:0]  o_addr;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: queue contents, edge index at which each register was last issued as rd.
  logic [23:0] m_q [$];
  int          last_wr [16];
  logic        e_iv;
  logic [23:0] e_ins;
  logic [15:0] e_stall;

  logic [23:0] s_list [$];
  int          s_idx;

  pipe_issue #(.FIFO_DEPTH(DEPTH), .HAZ_WIN(HZ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .issue_valid (issue_valid),
    .rs1         (o_rs1),
    .rs2         (o_rs2),
    .rd          (o_rd),
    .func        (o_func),
    .addr        (o_addr),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input int f, input int a1, input int a2, input int d, input int ad);
    return {f[3:0], a1[3:0], a2[3:0], d[3:0], ad[7:0]};
  endfunction

  function automatic logic [41:0] dut_obs();
    return {issue_valid, o_func, o_rs1, o_rs2, o_rd, o_addr, in_ready, stall_cnt};
  endfunction

  function automatic logic [41:0] exp_obs();
    return {e_iv, e_ins, (m_q.size() < DEPTH), e_stall};
  endfunction

  // A register is still in flight if it was issued fewer than HZ edges ago.
  function automatic bit recent(input logic [3:0] r);
    return (cyc - last_wr[r]) < HZ;
  endfunction

  task automatic model_reset();
    m_q.delete();
    foreach (last_wr[i]) last_wr[i] = -100;
    e_iv = 1'b0;
    e_ins = '0;
    e_stall = '0;
  endtask

  task automatic model_step();
    int sz;
    logic [23:0] h;
    sz = m_q.size();
    e_iv = 1'b0;
    e_ins = '0;
    if (flush) begin
      m_q.delete();
      foreach (last_wr[i]) last_wr[i] = -100;
      e_stall = '0;
    end else begin
      if (sz > 0) begin
        h = m_q[0];
        if (recent(h[19:16]) || recent(h[15:12])) begin
          if (STATS && e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
        end else begin
          e_iv = 1'b1;
          e_ins = h;
          last_wr[h[11:8]] = cyc + 1;
          void'(m_q.pop_front());
        end
      end
      if (in_valid && sz < DEPTH) m_q.push_back(in_instr);
    end
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed();
    bit acc;
    if (s_idx < s_list.size()) begin
      in_valid = 1'b1;
      in_instr = s_list[s_idx];
    end else begin
      in_valid = 1'b0;
      in_instr = 24'($urandom);
    end
    acc = in_valid && (m_q.size() < DEPTH);
    tick();
    if (acc) s_idx++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    s_list.delete();
    s_idx = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut_obs() !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", dut_obs(), RST_OBS);
    end
    do_reset();
    s_list.push_back(mk(0, 1, 2, 3, 8'h5A));
    for (int c = 0; c < 2; c++) begin
      feed();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL reset_pre cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_obs() !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_async got=%h want=%h", dut_obs(), RST_OBS);
    end
    do_reset();
  endtask

  task automatic test_independent();
    int t[$];
    do_reset();
    s_list.push_back(mk(0, 3, 5, 10, $urandom_range(0, 255)));
    s_list.push_back(mk(2, 3, 0, 12, $urandom_range(0, 255)));
    for (int c = 0; c < 6; c++) begin
      feed();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL indep cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
      if (issue_valid === 1'b1) t.push_back(c);
    end
    n_cmp++;
    if (t.size() != 2 || t[1] - t[0] != 1) begin
      n_fail++;
      $display("FAIL indep_b2b issues=%0d want=2 consecutive", t.size());
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL indep_stall got=%0d want=0", stall_cnt);
    end
  endtask

  task automatic test_hazard();
    int t[$];
    do_reset();
    s_list.push_back(mk(0, 1, 2, 10, 8'h11));
    s_list.push_back(mk(1, 10, 5, 14, 8'h22));
    for (int c = 0; c < 8; c++) begin
      feed();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL hazard cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
      if (issue_valid === 1'b1) t.push_back(c);
    end
    n_cmp++;
    if (t.size() != 2 || t[1] - t[0] - 1 != HZ) begin
      n_fail++;
      $display("FAIL hazard_bubbles issues=%0d want %0d bubbles between 2 issues", t.size(), HZ);
    end
    n_cmp++;
    if (stall_cnt !== (STATS ? 16'd2 : 16'd0)) begin
      n_fail++;
      $display("FAIL hazard_stall got=%0d want=%0d", stall_cnt, STATS ? 2 : 0);
    end
  endtask

  task automatic test_full();
    logic [3:0] seen[$];
    bit saw_full = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) s_list.push_back(mk($urandom_range(0, 11), k + 1, k + 1, k + 2, k));
    for (int c = 0; c < 26; c++) begin
      feed();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL full cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
      if (in_ready === 1'b0) saw_full = 1'b1;
      if (issue_valid === 1'b1) seen.push_back(o_rd);
    end
    n_cmp++;
    if (!saw_full) begin
      n_fail++;
      $display("FAIL full_ready got=never_low want=low_once");
    end
    n_cmp++;
    if (seen.size() != 6) begin
      n_fail++;
      $display("FAIL full_count got=%0d want=6", seen.size());
    end
    for (int k = 0; k < seen.size(); k++) begin
      n_cmp++;
      if (seen[k] !== 4'(k + 2)) begin
        n_fail++;
        $display("FAIL full_order idx=%0d got=%0d want=%0d", k, seen[k], k + 2);
      end
    end
  endtask

  task automatic test_flush();
    int issues = 0;
    do_reset();
    for (int k = 0; k < 5; k++) s_list.push_back(mk(0, k + 1, k + 1, k + 2, 8'h40 + k));
    for (int c = 0; c < 5; c++) begin
      feed();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL flush_pre cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(7, 9, 9, 15, 8'hEE);
    tick();
    n_cmp++;
    if (issue_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_now got=v%b r%b want=v0 r1", issue_valid, in_ready);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL flush_post cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
      if (issue_valid === 1'b1) issues++;
    end
    n_cmp++;
    if (issues != 0) begin
      n_fail++;
      $display("FAIL flush_drop got=%0d issues want=0", issues);
    end
  endtask

  task automatic test_reset_mid();
    int issues = 0;
    do_reset();
    s_list.push_back(mk(0, 4, 4, 1, 8'h01));
    s_list.push_back(mk(1, 1, 2, 3, 8'h02));
    s_list.push_back(mk(2, 1, 1, 5, 8'h03));
    for (int c = 0; c < 3; c++) begin
      feed();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL rstmid_pre cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_obs() !== RST_OBS) begin
      n_fail++;
      $display("FAIL rstmid_async got=%h want=%h", dut_obs(), RST_OBS);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL rstmid_post cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
      if (issue_valid === 1'b1) issues++;
    end
    n_cmp++;
    if (issues != 0) begin
      n_fail++;
      $display("FAIL rstmid_drop got=%0d issues want=0", issues);
    end
  endtask

  task automatic test_wrap();
    int issues = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_instr = mk(k % 12, 0, 0, k + 1, k * 17);
      tick();
      in_valid = 1'b0;
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
      n_cmp++;
      if (issue_valid !== 1'b1 || o_rd !== 4'(k + 1) || o_addr !== 8'(k * 17)) begin
        n_fail++;
        $display("FAIL wrap_order idx=%0d got=v%b rd%0d want=v1 rd%0d", k, issue_valid, o_rd, k + 1);
      end
      if (issue_valid === 1'b1) issues++;
    end
    n_cmp++;
    if (issues != 8) begin
      n_fail++;
      $display("FAIL wrap_count got=%0d want=8", issues);
    end
  endtask

  task automatic test_random();
    logic [23:0] pend;
    bit acc;
    do_reset();
    pend = mk($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 255));
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_instr = pend;
      acc = in_valid && !flush && (m_q.size() < DEPTH);
      tick();
      if (acc) pend = mk($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 255));
      n_cmp++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_obs());
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    s_idx = 0;
    test_reset();
    test_independent();
    test_hazard();
    test_full();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
